// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard control for a five-stage pipeline (IF, ID, EXE, MEM, WB).
// It selects operand forwarding sources for the instruction in ID and produces
// per-stage enables and flushes for the following:
//   - load-use stalls
//   - multi-cycle (MDU) operations
//   - data-memory waits
//   - debug single-stepping
//   - branch delay-slot flushes
//
// Parameters
//   ADDR_W     : register address width
//   MDU_LAT    : EXE occupancy of a multi-cycle op, legal 2..15
//   DELAY_SLOT : 1 = delay slot executes, 0 = slot after a taken branch is flushed
//
// Ports
//   clk, rst                    : clock, synchronous active-high reset
//   debug_en, debug_step        : single-step hold and step strobe
//   id_rs/id_rt (+ _used)       : ID source operands
//   id_is_store                 : ID instruction is a store; forwarding is suppressed
//   id_branch_taken             : ID instruction is a taken branch
//   exe_/mem_/wb_ wa/wen/flags  : destination info of the downstream stages
//   mem_req, mem_ack            : data-memory request / completion
//   fwd_a, fwd_b                : 0 regfile, 1 EXE ALU, 2 MEM ALU, 3 MEM load data
//   stage_en, stage_rst         : bit 0 = IF ... bit 4 = WB
//   busy                        : any stage held
//   stall_cycles                : saturating count of hazard stall cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int MDU_LAT    = 4,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_is_store,
    input  logic              id_branch_taken,
    input  logic [ADDR_W-1:0] exe_wa,
    input  logic [ADDR_W-1:0] mem_wa,
    input  logic [ADDR_W-1:0] wb_wa,
    input  logic              exe_wen,
    input  logic              exe_is_load,
    input  logic              exe_is_mdu,
    input  logic              mem_wen,
    input  logic              mem_is_load,
    input  logic              wb_wen,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [4:0]        stage_en,
    output logic [4:0]        stage_rst,
    output logic              busy,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_step_prev;
    logic [15:0] r_stall_cycles;

    logic [2:0]  w_fa;
    logic [2:0]  w_fb;
    logic        w_load_use;
    logic        w_mem_wait;
    logic        w_dbg_hold;
    logic        w_mdu_stall;
    logic        w_flush;
    logic        w_hazard_busy;
    logic        w_unused;

    // The register file writes in WB before ID reads it, so WB needs no forwarding path.
    assign w_unused = ^{wb_wa, wb_wen};

    // Forward select for one source: {load_use_hit, sel[1:0]}.
    // An EXE match wins over a MEM match because EXE holds the younger value.
    function automatic logic [2:0] fwd_calc(
        input logic [ADDR_W-1:0] src,
        input logic              used,
        input logic              is_store,
        input logic [ADDR_W-1:0] e_wa,
        input logic              e_wen,
        input logic              e_ld,
        input logic [ADDR_W-1:0] m_wa,
        input logic              m_wen,
        input logic              m_ld
    );
        logic [2:0] res;
        res = 3'b000;
        if (used && (src != {ADDR_W{1'b0}}) && !is_store) begin
            if (e_wen && (e_wa == src)) begin
                if (e_ld) res = 3'b100;
                else      res = 3'b001;
            end else if (m_wen && (m_wa == src)) begin
                if (m_ld) res = 3'b011;
                else      res = 3'b010;
            end else begin
                res = 3'b000;
            end
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    assign w_fa       = fwd_calc(id_rs, id_rs_used, id_is_store, exe_wa, exe_wen,
                                 exe_is_load, mem_wa, mem_wen, mem_is_load);
    assign w_fb       = fwd_calc(id_rt, id_rt_used, id_is_store, exe_wa, exe_wen,
                                 exe_is_load, mem_wa, mem_wen, mem_is_load);
    assign w_load_use = w_fa[2] | w_fb[2];
    assign w_mem_wait = mem_req & ~mem_ack;
    // A rising edge on debug_step lets exactly one cycle through the hold.
    assign w_dbg_hold = debug_en & ~(debug_step & ~r_step_prev);
    assign w_flush    = (DELAY_SLOT == 1'b0) & id_branch_taken;

    // MDU stall: the first cycle comes from RUN, and later cycles last while cnt is pending.
    always_comb begin
        w_mdu_stall = 1'b0;
        case (r_state)
            RUN:      w_mdu_stall = exe_is_mdu;
            MDU_WAIT: w_mdu_stall = (r_cnt != 4'd0);
            MEM_WAIT: w_mdu_stall = (r_cnt != 4'd0);
            default:  w_mdu_stall = 1'b0;
        endcase
    end

    // Stage control and forwarding, applied in fixed hazard priority order.
    always_comb begin
        fwd_a     = w_fa[1:0];
        fwd_b     = w_fb[1:0];
        stage_en  = 5'b11111;
        stage_rst = 5'b00000;
        if (rst) begin
            fwd_a     = 2'd0;
            fwd_b     = 2'd0;
            stage_rst = 5'b11111;
        end else if (w_mem_wait) begin
            stage_en  = 5'b10000;
            stage_rst = 5'b10000;
        end else if (w_dbg_hold) begin
            stage_en  = 5'b00000;
        end else if (w_mdu_stall) begin
            stage_en  = 5'b11000;
            stage_rst = 5'b01000;
        end else if (w_load_use) begin
            stage_en  = 5'b11100;
            stage_rst = 5'b00100;
        end else if (w_flush) begin
            stage_rst = 5'b00001;
        end else begin
            stage_en  = 5'b11111;
            stage_rst = 5'b00000;
        end
    end

    assign busy          = ~rst & (stage_en != 5'b11111);
    assign w_hazard_busy = ~rst & (w_mem_wait | (~w_dbg_hold & (w_mdu_stall | w_load_use)));
    assign stall_cycles  = r_stall_cycles;

    // Stall FSM and down-counter. The counter keeps running through a memory
    // wait. A debug hold freezes the FSM and the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else if (w_mem_wait) begin
            r_state <= MEM_WAIT;
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            else               r_cnt <= r_cnt;
        end else if (w_dbg_hold) begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
        end else begin
            case (r_state)
                RUN: begin
                    if (exe_is_mdu) begin
                        r_state <= MDU_WAIT;
                        r_cnt   <= 4'(MDU_LAT - 2);
                    end else begin
                        r_state <= RUN;
                        r_cnt   <= r_cnt;
                    end
                end
                MDU_WAIT, MEM_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_state <= MDU_WAIT;
                        r_cnt   <= r_cnt - 4'd1;
                    end else begin
                        r_state <= RUN;
                        r_cnt   <= r_cnt;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Previous debug_step value, used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) r_step_prev <= 1'b0;
        else     r_step_prev <= debug_step;
    end

    // Saturating count of cycles lost to hazards. Debug-hold cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst)                                          r_stall_cycles <= 16'd0;
        else if (w_hazard_busy && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
        else                                              r_stall_cycles <= r_stall_cycles;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, debug_en, debug_step;
    logic [4:0]  id_rs, id_rt, exe_wa, mem_wa, wb_wa;
    logic        id_rs_used, id_rt_used, id_is_store, id_branch_taken;
    logic        exe_wen, exe_is_load, exe_is_mdu, mem_wen, mem_is_load, wb_wen;
    logic        mem_req, mem_ack;
    logic [1:0]  fwd_a, fwd_b, fwd_a1, fwd_b1;
    logic [4:0]  stage_en, stage_rst, stage_en1, stage_rst1;
    logic        busy, busy1;
    logic [15:0] stall_cycles, stall_cycles1;

    typedef struct {
        string       tag;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [4:0]  en;
        logic [4:0]  sr;
        logic        bz;
        logic [15:0] sc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_sc = 16'd0;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ADDR_W(5), .MDU_LAT(4), .DELAY_SLOT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_branch_taken(id_branch_taken),
        .exe_wa(exe_wa), .mem_wa(mem_wa), .wb_wa(wb_wa),
        .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_is_mdu(exe_is_mdu),
        .mem_wen(mem_wen), .mem_is_load(mem_is_load), .wb_wen(wb_wen),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_en(stage_en), .stage_rst(stage_rst),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.ADDR_W(5), .MDU_LAT(4), .DELAY_SLOT(1'b1)) u_dut_ds (
        .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_is_store(id_is_store), .id_branch_taken(id_branch_taken),
        .exe_wa(exe_wa), .mem_wa(mem_wa), .wb_wa(wb_wa),
        .exe_wen(exe_wen), .exe_is_load(exe_is_load), .exe_is_mdu(exe_is_mdu),
        .mem_wen(mem_wen), .mem_is_load(mem_is_load), .wb_wen(wb_wen),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stage_en(stage_en1), .stage_rst(stage_rst1),
        .busy(busy1), .stall_cycles(stall_cycles1)
    );

    task automatic cmp(input string tag, input string fld, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else $error("FAIL %s.%s got=%0h want=%0h", tag, fld, got, want);
    endtask

    task automatic clr();
        rst = 1'b0; debug_en = 1'b0; debug_step = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; exe_wa = 5'd0; mem_wa = 5'd0; wb_wa = 5'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_store = 1'b0; id_branch_taken = 1'b0;
        exe_wen = 1'b0; exe_is_load = 1'b0; exe_is_mdu = 1'b0;
        mem_wen = 1'b0; mem_is_load = 1'b0; wb_wen = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Push the expectation for the inputs just driven, then pop and compare it
    // mid-cycle. hz marks a hazard stall cycle that advances the stall model.
    // ds checks the delay-slot instance, which must never flush IF.
    task automatic cyc(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [4:0] en, input logic [4:0] sr, input logic bz,
                       input bit hz, input bit ds = 1'b0);
        exp_t e;
        e.tag = tag; e.fa = fa; e.fb = fb; e.en = en; e.sr = sr; e.bz = bz; e.sc = m_sc;
        sb_q.push_back(e);
        if (hz) m_sc = m_sc + 16'd1;
        @(negedge clk);
        e = sb_q.pop_front();
        cmp(e.tag, "fwd_a", {14'd0, fwd_a}, {14'd0, e.fa});
        cmp(e.tag, "fwd_b", {14'd0, fwd_b}, {14'd0, e.fb});
        cmp(e.tag, "stage_en", {11'd0, stage_en}, {11'd0, e.en});
        cmp(e.tag, "stage_rst", {11'd0, stage_rst}, {11'd0, e.sr});
        cmp(e.tag, "busy", {15'd0, busy}, {15'd0, e.bz});
        cmp(e.tag, "stall_cycles", stall_cycles, e.sc);
        if (ds) begin
            cmp(e.tag, "ds_stage_rst", {11'd0, stage_rst1}, 16'd0);
            cmp(e.tag, "ds_stage_en", {11'd0, stage_en1}, {11'd0, e.en});
            cmp(e.tag, "ds_fwd_a", {14'd0, fwd_a1}, {14'd0, e.fa});
            cmp(e.tag, "ds_stall_cycles", stall_cycles1, e.sc);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset overrides everything
        rst = 1'b1; mem_req = 1'b1; exe_is_mdu = 1'b1; debug_en = 1'b1;
        id_rs = 5'd3; id_rs_used = 1'b1; exe_wa = 5'd3; exe_wen = 1'b1;
        cyc("rst", 2'd0, 2'd0, 5'b11111, 5'b11111, 1'b0, 1'b0);
        clr();
        cyc("idle", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Forwarding
        clr(); id_rs = 5'd3; id_rs_used = 1'b1; exe_wa = 5'd3; exe_wen = 1'b1;
        cyc("fwd_exe", 2'd1, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        clr(); id_rs = 5'd5; id_rs_used = 1'b1; id_rt = 5'd5; id_rt_used = 1'b1;
        exe_wa = 5'd5; exe_wen = 1'b1; mem_wa = 5'd5; mem_wen = 1'b1; mem_is_load = 1'b1;
        cyc("exe_prio", 2'd1, 2'd1, 5'b11111, 5'b00000, 1'b0, 1'b0);
        clr(); id_rs = 5'd6; id_rs_used = 1'b1; id_rt = 5'd6; id_rt_used = 1'b0;
        mem_wa = 5'd6; mem_wen = 1'b1; mem_is_load = 1'b1; exe_wa = 5'd9; exe_wen = 1'b1;
        cyc("fwd_mem_ld", 2'd3, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        clr(); id_rs = 5'd7; id_rt = 5'd7; id_rt_used = 1'b1; mem_wa = 5'd7; mem_wen = 1'b1;
        cyc("fwd_mem_alu", 2'd0, 2'd2, 5'b11111, 5'b00000, 1'b0, 1'b0);
        clr(); id_rs = 5'd4; id_rs_used = 1'b1; exe_wa = 5'd4; mem_wa = 5'd4;
        cyc("no_wen", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        clr(); id_rs = 5'd0; id_rs_used = 1'b1; exe_wa = 5'd0; exe_wen = 1'b1; exe_is_load = 1'b1;
        cyc("r0", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        clr(); id_rs = 5'd8; id_rs_used = 1'b1; id_rt = 5'd8; id_rt_used = 1'b1; id_is_store = 1'b1;
        exe_wa = 5'd8; exe_wen = 1'b1; exe_is_load = 1'b1;
        cyc("store", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Load-use with a taken branch: flush deferred one cycle
        clr(); id_rs = 5'd3; id_rs_used = 1'b1; exe_wa = 5'd3; exe_wen = 1'b1;
        exe_is_load = 1'b1; id_branch_taken = 1'b1;
        cyc("load_use", 2'd0, 2'd0, 5'b11100, 5'b00100, 1'b1, 1'b1);
        clr(); id_rs = 5'd3; id_rs_used = 1'b1; mem_wa = 5'd3; mem_wen = 1'b1;
        mem_is_load = 1'b1; id_branch_taken = 1'b1;
        cyc("lu_flush", 2'd3, 2'd0, 5'b11111, 5'b00001, 1'b0, 1'b0, 1'b1);

        // Reset clears the stall counter, then an MDU op stalls for 3 cycles
        clr(); rst = 1'b1;
        cyc("rst2", 2'd0, 2'd0, 5'b11111, 5'b11111, 1'b0, 1'b0);
        m_sc = 16'd0;
        clr(); exe_is_mdu = 1'b1;
        cyc("mdu1", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        clr();
        cyc("mdu2", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        cyc("mdu3", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        cyc("mdu_rel", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        cyc("mdu_run", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Memory wait of 5 cycles
        clr(); mem_req = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc("memw", 2'd0, 2'd0, 5'b10000, 5'b10000, 1'b1, 1'b1);
        mem_ack = 1'b1;
        cyc("mem_ack", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // MDU overlapped by a longer memory wait
        clr(); exe_is_mdu = 1'b1;
        cyc("ovA_mdu", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        clr(); mem_req = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("ovA_mem", 2'd0, 2'd0, 5'b10000, 5'b10000, 1'b1, 1'b1);
        mem_ack = 1'b1;
        cyc("ovA_rel", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Memory wait shorter than the MDU op: the MDU still holds afterwards
        clr(); exe_is_mdu = 1'b1;
        cyc("ovB_mdu", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        clr(); mem_req = 1'b1;
        cyc("ovB_mem", 2'd0, 2'd0, 5'b10000, 5'b10000, 1'b1, 1'b1);
        mem_ack = 1'b1;
        cyc("ovB_mdu2", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        clr();
        cyc("ovB_rel", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Debug single step
        clr(); debug_en = 1'b1;
        cyc("dbg_hold1", 2'd0, 2'd0, 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc("dbg_hold2", 2'd0, 2'd0, 5'b00000, 5'b00000, 1'b1, 1'b0);
        debug_step = 1'b1;
        cyc("dbg_step", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        cyc("dbg_hold3", 2'd0, 2'd0, 5'b00000, 5'b00000, 1'b1, 1'b0);
        debug_step = 1'b0;
        cyc("dbg_hold4", 2'd0, 2'd0, 5'b00000, 5'b00000, 1'b1, 1'b0);
        mem_req = 1'b1;
        cyc("dbg_memw", 2'd0, 2'd0, 5'b10000, 5'b10000, 1'b1, 1'b1);
        clr();
        cyc("dbg_off", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Debug hold freezes the MDU counter
        clr(); exe_is_mdu = 1'b1;
        cyc("frz_mdu", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        clr(); debug_en = 1'b1;
        cyc("frz_hold1", 2'd0, 2'd0, 5'b00000, 5'b00000, 1'b1, 1'b0);
        cyc("frz_hold2", 2'd0, 2'd0, 5'b00000, 5'b00000, 1'b1, 1'b0);
        debug_en = 1'b0;
        cyc("frz_mdu2", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        cyc("frz_mdu3", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        cyc("frz_rel", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        // Reset in MDU_WAIT with cnt=2 abandons the operation
        clr(); exe_is_mdu = 1'b1;
        cyc("rmdu", 2'd0, 2'd0, 5'b11000, 5'b01000, 1'b1, 1'b1);
        clr(); rst = 1'b1;
        cyc("rmdu_rst", 2'd0, 2'd0, 5'b11111, 5'b11111, 1'b0, 1'b0);
        m_sc = 16'd0;
        clr();
        cyc("rmdu_run1", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);
        cyc("rmdu_run2", 2'd0, 2'd0, 5'b11111, 5'b00000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
